// File: rtl/if_fetch_stage_pkg.sv
// Shared definitions for the MIPS instruction-fetch stage: FSM states, NOP word, default vectors.
package if_fetch_stage_pkg;

  typedef enum logic [1:0] {
    IF_IDLE  = 2'd0,
    IF_FETCH = 2'd1,
    IF_HOLD  = 2'd2,
    IF_DRAIN = 2'd3
  } if_state_e;

  localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;
  localparam logic [31:0] DEF_RESET_PC = 32'h0040_0000;
  localparam logic [31:0] DEF_EXC_PC   = 32'h8000_0180;

endpackage

// File: rtl/if_fetch_stage_ifid_reg.sv
// IF/ID pipeline register: flush beats stall beats load; with none of them a bubble is inserted.
module ifid_reg
  import if_fetch_stage_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_load,
  input  logic        i_stall,
  input  logic        i_flush,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_pc,
  output logic        o_valid,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc,
  output logic [31:0] o_pc4
);

  logic        r_valid;
  logic [31:0] r_instr;
  logic [31:0] r_pc;
  logic [31:0] r_pc4;

  // A bubble only clears valid/instr; the PC fields keep their last value.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
      r_instr <= NOP_INSTR;
      r_pc    <= '0;
      r_pc4   <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
      r_instr <= NOP_INSTR;
    end else if (i_stall) begin
      r_valid <= r_valid;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_instr <= i_instr;
      r_pc    <= i_pc;
      r_pc4   <= i_pc + 32'd4;
    end else begin
      r_valid <= 1'b0;
      r_instr <= NOP_INSTR;
    end
  end

  assign o_valid = r_valid;
  assign o_instr = r_instr;
  assign o_pc    = r_pc;
  assign o_pc4   = r_pc4;

endmodule

// File: rtl/if_fetch_stage.sv
// MIPS instruction-fetch stage: PC register, imem req/rvalid FSM, hold buffer, redirect, IF/ID register.
// Optional IF_MISALIGN_EN: misaligned PC loads trap to EXC_PC and raise if_misalign_o/if_badaddr_o.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter logic [31:0] EXC_PC   = DEF_EXC_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] newpc,
  input  logic        stall_i,
  input  logic        flush_i,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_o,
  output logic        ifid_valid,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc,
`ifdef IF_MISALIGN_EN
  output logic        if_misalign_o,
  output logic [31:0] if_badaddr_o,
`endif
  output logic [31:0] ifid_pc4
);

  if (RESET_PC[1:0] != 2'b00 || EXC_PC[1:0] != 2'b00) begin : g_bad_vector
    $error("if_fetch_stage: RESET_PC and EXC_PC must be word aligned");
  end

  if_state_e   r_state;
  logic [31:0] r_pc;
  logic [31:0] r_hold_buf;
  logic [31:0] r_redirect;
`ifdef IF_MISALIGN_EN
  logic        r_misalign;
  logic [31:0] r_badaddr;
`endif

  logic        w_complete;
  logic        w_pc_load;
  logic [31:0] w_pc_next;
  logic        w_ifid_load;
  logic [31:0] w_ifid_instr;

  always_comb begin
    w_complete = (r_state == IF_FETCH) && imem_rvalid;
    w_pc_load  = 1'b0;
    w_pc_next  = newpc;
    case (r_state)
      IF_FETCH: w_pc_load = imem_rvalid && (flush_i || !stall_i);
      IF_HOLD:  w_pc_load = flush_i || !stall_i;
      IF_DRAIN: begin
        // A flush coinciding with the drained response wins over the stored redirect.
        w_pc_load = imem_rvalid;
        w_pc_next = flush_i ? newpc : r_redirect;
      end
      default:  w_pc_load = 1'b0;
    endcase
    w_ifid_load  = w_complete || (r_state == IF_HOLD);
    w_ifid_instr = (r_state == IF_HOLD) ? r_hold_buf : imem_rdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IF_IDLE;
      r_pc       <= RESET_PC;
      r_hold_buf <= '0;
      r_redirect <= '0;
`ifdef IF_MISALIGN_EN
      r_misalign <= 1'b0;
      r_badaddr  <= '0;
`endif
    end else begin
`ifdef IF_MISALIGN_EN
      r_misalign <= 1'b0;
      if (w_pc_load) begin
        if (w_pc_next[1:0] != 2'b00) begin
          r_pc       <= EXC_PC;
          r_misalign <= 1'b1;
          r_badaddr  <= w_pc_next;
        end else begin
          r_pc <= w_pc_next;
        end
      end
`else
      if (w_pc_load) r_pc <= {w_pc_next[31:2], 2'b00};
`endif
      case (r_state)
        IF_IDLE:  r_state <= IF_FETCH;
        IF_FETCH: begin
          if (flush_i && !imem_rvalid) begin
            r_redirect <= newpc;
            r_state    <= IF_DRAIN;
          end else if (imem_rvalid && stall_i && !flush_i) begin
            r_hold_buf <= imem_rdata;
            r_state    <= IF_HOLD;
          end
        end
        IF_HOLD:  if (flush_i || !stall_i) r_state <= IF_FETCH;
        IF_DRAIN: begin
          if (flush_i)     r_redirect <= newpc;
          if (imem_rvalid) r_state    <= IF_FETCH;
        end
        default:  r_state <= IF_IDLE;
      endcase
    end
  end

  assign imem_req  = (r_state == IF_FETCH) || (r_state == IF_DRAIN);
  assign imem_addr = r_pc;
  assign pc_o      = r_pc;
`ifdef IF_MISALIGN_EN
  assign if_misalign_o = r_misalign;
  assign if_badaddr_o  = r_badaddr;
`endif

  ifid_reg u_ifid_reg (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_load  (w_ifid_load),
    .i_stall (stall_i),
    .i_flush (flush_i),
    .i_instr (w_ifid_instr),
    .i_pc    (r_pc),
    .o_valid (ifid_valid),
    .o_instr (ifid_instr),
    .o_pc    (ifid_pc),
    .o_pc4   (ifid_pc4)
  );

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: reset, zero-wait streaming, wait states, stall/HOLD, flush/DRAIN, misalign, wrap.
module tb_if_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic [31:0] newpc;
  logic        stall_i;
  logic        flush_i;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] pc_o;
  logic        ifid_valid;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_pc4;
`ifdef IF_MISALIGN_EN
  logic        if_misalign_o;
  logic [31:0] if_badaddr_o;
`endif

  // Stimulus controls: zero-wait memory echoes req, otherwise rvalid/rdata are driven directly.
  logic        r_zw;
  logic        r_mvalid;
  logic [31:0] r_mdata;
  logic        r_np_inc;
  logic [31:0] r_np_val;

  int unsigned n_cmp;
  int unsigned n_bad;

  if_fetch_stage #(
    .RESET_PC (32'h0040_0000),
    .EXC_PC   (32'h8000_0180)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .newpc       (newpc),
    .stall_i     (stall_i),
    .flush_i     (flush_i),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .pc_o        (pc_o),
    .ifid_valid  (ifid_valid),
    .ifid_instr  (ifid_instr),
    .ifid_pc     (ifid_pc),
`ifdef IF_MISALIGN_EN
    .if_misalign_o (if_misalign_o),
    .if_badaddr_o  (if_badaddr_o),
`endif
    .ifid_pc4    (ifid_pc4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    newpc       = r_np_inc ? (pc_o + 32'd4) : r_np_val;
    imem_rvalid = r_zw ? imem_req : r_mvalid;
    imem_rdata  = r_zw ? (imem_addr ^ 32'hA5A5_0000) : r_mdata;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    rst_n    = 1'b0;
    stall_i  = 1'b0;
    flush_i  = 1'b0;
    r_zw     = 1'b0;
    r_mvalid = 1'b0;
    r_mdata  = '0;
    r_np_inc = 1'b1;
    r_np_val = '0;

    // Reset, then one IDLE cycle, then FETCH at RESET_PC
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc", pc_o, 32'h0040_0000);
    chk("rst_valid", {31'd0, ifid_valid}, 32'd0);
    chk("rst_instr", ifid_instr, 32'd0);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("fetch_req", {31'd0, imem_req}, 32'd1);
    chk("fetch_addr", imem_addr, 32'h0040_0000);

    // Zero-wait memory: one instruction per cycle
    r_zw = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("zw_valid", {31'd0, ifid_valid}, 32'd1);
      chk("zw_pc", ifid_pc, 32'h0040_0000 + 32'(4 * i));
      chk("zw_instr", ifid_instr, 32'hA5E5_0000 + 32'(4 * i));
    end
    chk("zw_pc_o", pc_o, 32'h0040_000C);

    // Three wait states before rvalid
    r_zw    = 1'b0;
    r_mdata = 32'h1234_5678;
    chk("ws_addr0", imem_addr, 32'h0040_000C);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ws_addr", imem_addr, 32'h0040_000C);
      chk("ws_bubble", {31'd0, ifid_valid}, 32'd0);
    end
    r_mvalid = 1'b1;
    tick();
    r_mvalid = 1'b0;
    chk("ws_valid", {31'd0, ifid_valid}, 32'd1);
    chk("ws_instr", ifid_instr, 32'h1234_5678);
    chk("ws_pc", ifid_pc, 32'h0040_000C);
    chk("ws_pc4", ifid_pc4, 32'h0040_0010);
    chk("ws_pc_o", pc_o, 32'h0040_0010);

    // Stall when the response lands: HOLD, then release
    stall_i  = 1'b1;
    r_mvalid = 1'b1;
    r_mdata  = 32'h8C82_0004;
    tick();
    r_mvalid = 1'b0;
    chk("hold_req", {31'd0, imem_req}, 32'd0);
    chk("hold_instr", ifid_instr, 32'h1234_5678);
    chk("hold_pc_o", pc_o, 32'h0040_0010);
    tick();
    chk("hold2_req", {31'd0, imem_req}, 32'd0);
    chk("hold2_valid", {31'd0, ifid_valid}, 32'd1);
    stall_i = 1'b0;
    tick();
    chk("unhold_instr", ifid_instr, 32'h8C82_0004);
    chk("unhold_pc", ifid_pc, 32'h0040_0010);
    chk("unhold_pc4", ifid_pc4, 32'h0040_0014);
    chk("unhold_pc_o", pc_o, 32'h0040_0014);
    chk("unhold_req", {31'd0, imem_req}, 32'd1);

    // Flush while waiting: DRAIN keeps the killed address, late data dropped
    r_np_inc = 1'b0;
    r_np_val = 32'h0040_0100;
    flush_i  = 1'b1;
    tick();
    flush_i  = 1'b0;
    r_np_val = 32'hDEAD_0000;
    chk("drain_valid", {31'd0, ifid_valid}, 32'd0);
    chk("drain_instr", ifid_instr, 32'd0);
    chk("drain_req", {31'd0, imem_req}, 32'd1);
    chk("drain_addr", imem_addr, 32'h0040_0014);
    tick();
    chk("drain2_addr", imem_addr, 32'h0040_0014);
    r_mvalid = 1'b1;
    r_mdata  = 32'hFFFF_FFFF;
    tick();
    r_mvalid = 1'b0;
    chk("redir_addr", imem_addr, 32'h0040_0100);
    chk("redir_valid", {31'd0, ifid_valid}, 32'd0);
    chk("redir_instr", ifid_instr, 32'd0);

    // Misaligned target
    r_np_val = 32'h0040_0102;
    r_mvalid = 1'b1;
    r_mdata  = 32'h0123_4567;
    tick();
    r_mvalid = 1'b0;
    chk("mis_instr", ifid_instr, 32'h0123_4567);
`ifdef IF_MISALIGN_EN
    chk("mis_pc_o", pc_o, 32'h8000_0180);
    chk("mis_pulse", {31'd0, if_misalign_o}, 32'd1);
    chk("mis_bad", if_badaddr_o, 32'h0040_0102);
`else
    chk("mis_pc_o", pc_o, 32'h0040_0100);
`endif

    // Flush with a completing fetch, to the top of the address space, then pc4 wrap
    r_np_val = 32'hFFFF_FFFC;
    flush_i  = 1'b1;
    r_mvalid = 1'b1;
    tick();
    flush_i  = 1'b0;
    chk("wrapf_pc_o", pc_o, 32'hFFFF_FFFC);
    chk("wrapf_valid", {31'd0, ifid_valid}, 32'd0);
`ifdef IF_MISALIGN_EN
    chk("mis_pulse_end", {31'd0, if_misalign_o}, 32'd0);
    chk("mis_bad_held", if_badaddr_o, 32'h0040_0102);
`endif
    r_mdata  = 32'hCAFE_F00D;
    r_np_val = 32'h0040_0000;
    tick();
    r_mvalid = 1'b0;
    chk("wrap_pc", ifid_pc, 32'hFFFF_FFFC);
    chk("wrap_pc4", ifid_pc4, 32'h0000_0000);
    chk("wrap_pc_o", pc_o, 32'h0040_0000);

    // Flush beats stall in HOLD
    stall_i  = 1'b1;
    r_mvalid = 1'b1;
    r_mdata  = 32'h1111_1111;
    tick();
    r_mvalid = 1'b0;
    chk("hf_hold_instr", ifid_instr, 32'hCAFE_F00D);
    flush_i  = 1'b1;
    r_np_val = 32'h0040_0200;
    tick();
    flush_i  = 1'b0;
    stall_i  = 1'b0;
    chk("hf_valid", {31'd0, ifid_valid}, 32'd0);
    chk("hf_instr", ifid_instr, 32'd0);
    chk("hf_pc_o", pc_o, 32'h0040_0200);
    chk("hf_req", {31'd0, imem_req}, 32'd1);

    // Reset mid-request with a response in flight
    rst_n    = 1'b0;
    r_mvalid = 1'b1;
    r_mdata  = 32'h2222_2222;
    tick();
    r_mvalid = 1'b0;
    chk("rst2_pc", pc_o, 32'h0040_0000);
    chk("rst2_req", {31'd0, imem_req}, 32'd0);
    chk("rst2_valid", {31'd0, ifid_valid}, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("rst2_fetch_req", {31'd0, imem_req}, 32'd1);
    chk("rst2_fetch_addr", imem_addr, 32'h0040_0000);
    chk("rst2_fetch_valid", {31'd0, ifid_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
